// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode, flag and state types for alu_seq
package alu_pkg;

    typedef enum logic [4:0] {
        OP_ADD   = 5'd0,
        OP_SUB   = 5'd1,
        OP_MUL   = 5'd2,
        OP_DIV   = 5'd3,
        OP_MOD   = 5'd4,
        OP_AND   = 5'd5,
        OP_OR    = 5'd6,
        OP_XOR   = 5'd7,
        OP_NAND  = 5'd8,
        OP_NOR   = 5'd9,
        OP_XNOR  = 5'd10,
        OP_NOT   = 5'd11,
        OP_NEG   = 5'd12,
        OP_SLL   = 5'd13,
        OP_SRL   = 5'd14,
        OP_SRA   = 5'd15,
        OP_SLT   = 5'd16,
        OP_SLTU  = 5'd17,
        OP_INC   = 5'd18,
        OP_DEC   = 5'd19,
        OP_ROTL  = 5'd20,
        OP_ROTR  = 5'd21,
        OP_PASSA = 5'd22,
        OP_PASSB = 5'd23
    } opcode_e;

    typedef struct packed {
        logic zero;
        logic carry;
        logic overflow;
        logic div_by_zero;
    } flags_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DIV  = 1'b1
    } state_e;

    function automatic logic is_div_op(input logic [4:0] op);
        return (op == OP_DIV) || (op == OP_MOD);
    endfunction

endpackage

// File: rtl/alu_divider.sv
// rtl/alu_divider.sv - restoring unsigned divider, one quotient bit per cycle (built only with ALU_SEQ_DIV_EN)
module alu_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
    logic [WIDTH-1:0] rem_d, quo_d;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic [WIDTH:0]   part, diff;

    // one restoring step: shift in the next dividend bit, subtract if it fits
    always_comb begin
        part  = {rem_q, quo_q[WIDTH-1]};
        diff  = part - {1'b0, dvs_q};
        rem_d = diff[WIDTH] ? part[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
    end

    // the step taken while the counter is 0 is the last; its result is final
    assign done      = busy_q && (cnt_q == '0);
    assign quotient  = quo_d;
    assign remainder = rem_d;

    // iteration registers; quo_q starts as the dividend and is shifted out MSB first
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start) begin
            rem_q  <= '0;
            quo_q  <= dividend;
            dvs_q  <= divisor;
            cnt_q  <= CW'(WIDTH - 1);
            busy_q <= 1'b1;
        end else if (busy_q) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            if (cnt_q == '0) busy_q <= 1'b0;
            else             cnt_q  <= cnt_q - 1'b1;
        end
    end
endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential ALU with valid/ready handshake; ALU_SEQ_DIV_EN enables the iterative divider
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry_out,
    output logic             overflow,
    output logic             div_by_zero
);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] result_q, result_d;
    flags_t           flags_q, flags_d;
    logic             out_valid_q, out_valid_d;

    logic [WIDTH-1:0] alu_res;
    flags_t           alu_flags;
    logic [WIDTH:0]   add_w, sub_w, inc_w, dec_w;
    logic [SHW-1:0]   shamt;
    logic             out_free, accept, load_single;

    assign add_w = {1'b0, a} + {1'b0, b};
    assign sub_w = {1'b0, a} - {1'b0, b};
    assign inc_w = {1'b0, a} + {1'b0, ONE};
    assign dec_w = {1'b0, a} - {1'b0, ONE};
    assign shamt = b[SHW-1:0];

    assign out_free = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // single-cycle datapath; unassigned opcodes fall through to result 0
    always_comb begin
        alu_res   = '0;
        alu_flags = '0;
        case (opcode)
            OP_ADD: begin
                alu_res            = add_w[WIDTH-1:0];
                alu_flags.carry    = add_w[WIDTH];
                alu_flags.overflow = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res            = sub_w[WIDTH-1:0];
                alu_flags.carry    = sub_w[WIDTH];
                alu_flags.overflow = (a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_MUL:   alu_res = a * b;
`ifdef ALU_SEQ_DIV_EN
            // only the b == 0 case completes here; b != 0 goes to the divider
            OP_DIV, OP_MOD: alu_flags.div_by_zero = (b == '0);
`endif
            OP_AND:   alu_res = a & b;
            OP_OR:    alu_res = a | b;
            OP_XOR:   alu_res = a ^ b;
            OP_NAND:  alu_res = ~(a & b);
            OP_NOR:   alu_res = ~(a | b);
            OP_XNOR:  alu_res = ~(a ^ b);
            OP_NOT:   alu_res = ~a;
            OP_NEG:   alu_res = ~a + ONE;
            OP_SLL:   alu_res = a << shamt;
            OP_SRL:   alu_res = a >> shamt;
            OP_SRA:   alu_res = $signed(a) >>> shamt;
            OP_SLT:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU:  alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_INC: begin
                alu_res         = inc_w[WIDTH-1:0];
                alu_flags.carry = inc_w[WIDTH];
            end
            OP_DEC: begin
                alu_res         = dec_w[WIDTH-1:0];
                alu_flags.carry = dec_w[WIDTH];
            end
            OP_ROTL:  alu_res = {a[WIDTH-2:0], a[WIDTH-1]};
            OP_ROTR:  alu_res = {a[0], a[WIDTH-1:1]};
            OP_PASSA: alu_res = a;
            OP_PASSB: alu_res = b;
            default:  alu_res = '0;
        endcase
        alu_flags.zero = (alu_res == '0);
    end

`ifdef ALU_SEQ_DIV_EN
    state_e           state_q, state_d;
    logic             is_mod_q, is_mod_d;
    logic             div_start, div_done;
    logic [WIDTH-1:0] div_quo, div_rem;

    alu_divider #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .dividend  (a),
        .divisor   (b),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    assign in_ready    = (state_q == ST_IDLE) && out_free;
    assign load_single = accept && !(is_div_op(opcode) && (b != '0));

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            is_mod_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            is_mod_q <= is_mod_d;
        end
    end

    // FSM next state: launch the divider on a nonzero-divisor DIV/MOD, return when it finishes
    always_comb begin
        state_d   = state_q;
        is_mod_d  = is_mod_q;
        div_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept && is_div_op(opcode) && (b != '0)) begin
                    state_d   = ST_DIV;
                    div_start = 1'b1;
                    is_mod_d  = (opcode == OP_MOD);
                end
            end
            ST_DIV:  if (div_done) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end
`else
    assign in_ready    = out_free;
    assign load_single = accept;
`endif

    // output register next state: drain, then let a new result overwrite on the same edge
    always_comb begin
        result_d    = result_q;
        flags_d     = flags_q;
        out_valid_d = out_valid_q;
        if (out_valid_q && out_ready) out_valid_d = 1'b0;
        if (load_single) begin
            result_d    = alu_res;
            flags_d     = alu_flags;
            out_valid_d = 1'b1;
        end
`ifdef ALU_SEQ_DIV_EN
        if (div_done) begin
            result_d     = is_mod_q ? div_rem : div_quo;
            flags_d      = '0;
            flags_d.zero = (result_d == '0);
            out_valid_d  = 1'b1;
        end
`endif
    end

    // output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q    <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            result_q    <= result_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign result      = result_q;
    assign zero        = flags_q.zero;
    assign carry_out   = flags_q.carry;
    assign overflow    = flags_q.overflow;
    assign div_by_zero = flags_q.div_by_zero;
endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq at WIDTH=16 and WIDTH=32
module tb_alu_seq;
    import alu_pkg::*;

`ifdef ALU_SEQ_DIV_EN
    localparam int          DIV_LAT  = 17;
    localparam int          DIV_BUSY = 16;
    localparam logic [15:0] DIV_Q    = 16'h000A;
    localparam logic [15:0] MOD_R    = 16'h0001;
    localparam logic        DIV_Z    = 1'b0;
    localparam logic        DBZ      = 1'b1;
`else
    localparam int          DIV_LAT  = 1;
    localparam int          DIV_BUSY = 0;
    localparam logic [15:0] DIV_Q    = 16'h0000;
    localparam logic [15:0] MOD_R    = 16'h0000;
    localparam logic        DIV_Z    = 1'b1;
    localparam logic        DBZ      = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_run  = 0;
    int n_fail = 0;

    logic        iv16, ir16, ov16, or16, z16, c16, o16, d16;
    logic [15:0] a16, b16, r16;
    logic [4:0]  op16;

    logic        iv32, ir32, ov32, or32, z32, c32, o32, d32;
    logic [31:0] a32, b32, r32;
    logic [4:0]  op32;

    alu_seq #(.WIDTH(16)) u16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
        .opcode(op16), .out_valid(ov16), .out_ready(or16), .result(r16), .zero(z16),
        .carry_out(c16), .overflow(o16), .div_by_zero(d16)
    );

    alu_seq #(.WIDTH(32)) u32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
        .opcode(op32), .out_valid(ov32), .out_ready(or32), .result(r32), .zero(z32),
        .carry_out(c32), .overflow(o32), .div_by_zero(d32)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_run++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue16(input logic [4:0] op, input logic [15:0] ta, input logic [15:0] tb_,
                           output int lat, output int busy);
        op16 = op; a16 = ta; b16 = tb_; iv16 = 1'b1;
        step();
        iv16 = 1'b0;
        lat = 1; busy = 0;
        while (!ov16 && lat < 40) begin
            if (!ir16) busy++;
            step();
            lat++;
        end
    endtask

    task automatic issue32(input logic [4:0] op, input logic [31:0] ta, input logic [31:0] tb_,
                           output int lat);
        op32 = op; a32 = ta; b32 = tb_; iv32 = 1'b1;
        step();
        iv32 = 1'b0;
        lat = 1;
        while (!ov32 && lat < 40) begin
            step();
            lat++;
        end
    endtask

    initial begin
        int lat, busy, seen;
        rst = 1'b1;
        iv16 = 0; a16 = '0; b16 = '0; op16 = '0; or16 = 1'b1;
        iv32 = 0; a32 = '0; b32 = '0; op32 = '0; or32 = 1'b1;
        #2;
        chk("rst_out_valid", ov16, 0);
        chk("rst_result", r16, 0);
        chk("rst_flags", {z16, c16, o16, d16}, 0);
        chk("rst_in_ready", ir16, 1);
        step(); step();
        rst = 1'b0;

        // back-to-back ADD then SUB, both overflowing
        op16 = OP_ADD; a16 = 16'h7FFF; b16 = 16'h0001; iv16 = 1'b1;
        #1 chk("add_in_ready", ir16, 1);
        step();
        chk("add_valid", ov16, 1);
        chk("add_result", r16, 16'h8000);
        chk("add_ovf_carry", {o16, c16}, 2'b10);
        op16 = OP_SUB; a16 = 16'h8000; b16 = 16'h0001;
        #1 chk("sub_in_ready", ir16, 1);
        step();
        iv16 = 1'b0;
        chk("sub_valid", ov16, 1);
        chk("sub_result", r16, 16'h7FFF);
        chk("sub_ovf_carry", {o16, c16}, 2'b10);
        step();
        chk("drain_idle", ov16, 0);

        // divide path
        issue16(OP_DIV, 16'h0064, 16'h000A, lat, busy);
        chk("div_latency", lat, DIV_LAT);
        chk("div_busy", busy, DIV_BUSY);
        chk("div_result", r16, DIV_Q);
        chk("div_flags", {z16, d16}, {DIV_Z, 1'b0});
        step();
        issue16(OP_MOD, 16'h0065, 16'h000A, lat, busy);
        chk("mod_result", r16, MOD_R);
        step();
        issue16(OP_DIV, 16'h0064, 16'h0000, lat, busy);
        chk("div0_latency", lat, 1);
        chk("div0_result", r16, 0);
        chk("div0_flags", {z16, c16, o16, d16}, {1'b1, 1'b0, 1'b0, DBZ});
        step();

        // backpressure then drain-and-reload on one edge
        or16 = 1'b0;
        issue16(OP_ADD, 16'h0010, 16'h0030, lat, busy);
        chk("bp_result", r16, 16'h0040);
        chk("bp_in_ready", ir16, 0);
        step(); step();
        chk("bp_hold_result", r16, 16'h0040);
        chk("bp_hold_valid", ov16, 1);
        chk("bp_hold_in_ready", ir16, 0);
        or16 = 1'b1;
        op16 = OP_PASSB; a16 = 16'h0000; b16 = 16'h1234; iv16 = 1'b1;
        #1 chk("reload_in_ready", ir16, 1);
        step();
        iv16 = 1'b0;
        chk("reload_valid", ov16, 1);
        chk("reload_result", r16, 16'h1234);
        step();
        chk("reload_drained", ov16, 0);

        // reset in the middle of a divide
        op16 = OP_DIV; a16 = 16'h0064; b16 = 16'h000A; iv16 = 1'b1;
        step();
        iv16 = 1'b0;
        step(); step(); step(); step();
        rst = 1'b1;
        #1;
        chk("async_rst_valid", ov16, 0);
        chk("async_rst_result", r16, 0);
        chk("async_rst_flags", {z16, c16, o16, d16}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (ov16) seen++;
            step();
        end
        chk("no_ghost_result", seen, 0);
        issue16(OP_INC, 16'hFFFF, 16'h0000, lat, busy);
        chk("inc_latency", lat, 1);
        chk("inc_result", r16, 16'h0000);
        chk("inc_flags", {z16, c16, o16}, 3'b110);
        step();

        // assorted single-cycle vectors
        issue16(OP_DEC, 16'h0000, 16'h0000, lat, busy);
        chk("dec_result", r16, 16'hFFFF);
        chk("dec_flags", {z16, c16, o16}, 3'b010);
        step();
        issue16(OP_SLT, 16'h8000, 16'h0001, lat, busy);
        chk("slt_result", r16, 16'h0001);
        step();
        issue16(OP_SLTU, 16'h8000, 16'h0001, lat, busy);
        chk("sltu_result", r16, 16'h0000);
        step();
        issue16(OP_XNOR, 16'h0F0F, 16'h00FF, lat, busy);
        chk("xnor_result", r16, 16'hF00F);
        step();
        issue16(OP_NEG, 16'h0001, 16'h0000, lat, busy);
        chk("neg_result", r16, 16'hFFFF);
        chk("neg_flags", {c16, o16}, 2'b00);
        step();
        issue16(OP_SRL, 16'h8000, 16'h0013, lat, busy);
        chk("srl_result", r16, 16'h1000);
        step();
        issue16(OP_MUL, 16'h0123, 16'h0010, lat, busy);
        chk("mul_result", r16, 16'h1230);
        step();

        // WIDTH=32 instance
        issue32(OP_SRA, 32'h8000_0000, 32'h0000_0004, lat);
        chk("sra32_result", r32, 32'hF800_0000);
        step();
        issue32(OP_ROTL, 32'h8000_0001, 32'h0, lat);
        chk("rotl32_result", r32, 32'h0000_0003);
        step();
        issue32(OP_ROTR, 32'h0000_0001, 32'h0, lat);
        chk("rotr32_result", r32, 32'h8000_0000);
        step();
        issue32(5'd24, 32'h0000_0005, 32'h0000_0007, lat);
        chk("op24_result", r32, 32'h0);
        chk("op24_flags", {z32, c32, o32, d32}, 4'b1000);
        step();
        issue32(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, lat);
        chk("add32_result", r32, 32'h0);
        chk("add32_flags", {z32, c32, o32}, 3'b110);
        step();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
# alu_seq

Sequential, parametrised successor to the team's combinational 16-bit ALU. Keeps the 5-bit opcode set and the zero/carry/overflow flag semantics. Adds a registered valid/ready handshake on input and output, an iterative multi-cycle divider for DIV/MOD, and an explicit divide-by-zero flag. It sits between the operand-issue logic and the writeback stage, and accepts one operation per cycle except while a divide is in flight.

## Interface
- `WIDTH`, default 16: operand/result width in bits; legal values are powers of two, 8 to 64.
- `SHW`, default `$clog2(WIDTH)`: width of the shift amount; derived, not overridden.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst` input, 1 bit: reset, asynchronous and active-high.
- `in_valid` input, 1 bit: operands and opcode are valid.
- `in_ready` output, 1 bit: block can accept an operation this cycle.
- `a` input, WIDTH bits: operand A.
- `b` input, WIDTH bits: operand B.
- `opcode` input, 5 bits: operation select (encoding below).
- `out_valid` output, 1 bit: result and flags are valid.
- `out_ready` input, 1 bit: consumer accepts the result.
- `result` output, WIDTH bits: registered result.
- `zero` output, 1 bit: set when `result == 0`.
- `carry_out` output, 1 bit: carry, or borrow for SUB/DEC.
- `overflow` output, 1 bit: signed overflow (ADD/SUB only).
- `div_by_zero` output, 1 bit: set for DIV/MOD with `b == 0`.

## Operation
- Opcodes:
  - 0 ADD, 1 SUB, 2 MUL (low WIDTH bits), 3 DIV (unsigned), 4 MOD (unsigned).
  - 5 AND, 6 OR, 7 XOR, 8 NAND, 9 NOR, 10 XNOR, 11 NOT a, 12 NEG a.
  - 13 SLL, 14 SRL, 15 SRA, each by `b[SHW-1:0]`.
  - 16 SLT (signed), 17 SLTU.
  - 18 INC a, 19 DEC a.
  - 20 ROTL by 1, 21 ROTR by 1.
  - 22 PASS A, 23 PASS B.
  - 24–31 produce result 0 with `zero=1` and all other flags 0.
- Flags:
  - `carry_out` is driven only by ADD, SUB, INC and DEC. INC of all-ones gives carry=1. DEC of 0 gives borrow=1.
  - `overflow` is driven only by ADD and SUB. It is 0 for every other op.
- Divide:
  - Restoring, unsigned, one quotient bit per cycle, WIDTH iterations.
  - DIV returns the quotient; MOD returns the remainder.
  - `b == 0`: no iteration is performed; result 0, `zero=1`, `div_by_zero=1`.
- State machine, `IDLE → DIV → IDLE`:
  - DIV is entered on accepting DIV/MOD with `b != 0`.
  - In DIV the iteration counter runs from WIDTH-1 down to 0. At 0 the result is loaded into the output register and the block returns to IDLE.
- Output register:
  - A new result is loaded only when the output register is empty or is being drained that same cycle.
  - Result and flags are held stable while `out_valid && !out_ready`.

## Timing
- Reset values: `result=0`, all flags 0, `out_valid=0`, state IDLE, counter 0.
- Reset mid-operation (including mid-divide) discards all in-flight work immediately. No output is produced for the discarded operation.
- `in_ready = (state == IDLE) && (!out_valid || out_ready)`. This is combinational; no input may be accepted while in DIV.
- Transfer happens on an edge where `in_valid && in_ready`. An output transfer happens on an edge where `out_valid && out_ready`.
- Latency, counted in edges from the accepting edge to `out_valid=1`:
  - Single-cycle ops (including DIV/MOD by zero): 1.
  - DIV/MOD with `b != 0`: WIDTH+1.
- Throughput: one single-cycle op per clock while `out_ready` is held high.
- Simultaneous output drain and input accept on the same edge: the old result retires and the new result loads. `out_valid` stays 1.
- `out_valid` falls only on a drain edge with no concurrent load.

## Configuration
- `ALU_SEQ_DIV_EN` defined: iterative divider present; DIV/MOD behave as described above.
- `ALU_SEQ_DIV_EN` undefined:
  - Divider and DIV state are removed.
  - Opcodes 3 and 4 complete in 1 cycle as unimplemented ops: result 0, `zero=1`, `div_by_zero=0`.

## Structure
- Shared package `alu_pkg` holds:
  - The opcode enum (`OP_ADD` … `OP_PASSB`) at the fixed 5-bit encoding.
  - The flag struct (zero, carry, overflow, div_by_zero).
  - The state enum (`ST_IDLE`, `ST_DIV`).
- One sub-module, `alu_divider`:
  - Parametrised by WIDTH.
  - Inputs: start, dividend, divisor.
  - Outputs: done, quotient, remainder.
  - Compiled in only under `ALU_SEQ_DIV_EN`.
- Single-cycle datapath is combinational logic inside `alu_seq`, feeding the output register.

## Test plan
- WIDTH=16, back-to-back ADD 0x7FFF+0x0001 then SUB 0x8000−0x0001, `out_ready=1` → results 0x8000 (overflow=1) and 0x7FFF (overflow=1) on consecutive cycles; `in_ready` stays 1.
- DIV 0x0064/0x000A → `in_ready=0` for 16 cycles; result 0x000A after 17 edges. MOD 0x0065/0x000A → 0x0001.
- DIV 0x0064/0x0000 → 1-cycle latency; result 0, `zero=1`, `div_by_zero=1`.
- `out_ready=0` with ADD 0x0010+0x0030 → 0x0040 held stable; `in_ready=0` until drained. Asserting `out_ready` with a new valid op on the same edge drains and reloads with no bubble.
- Assert `rst` on cycle 5 of a divide → all outputs 0 asynchronously. No result appears after release; the next INC 0xFFFF → 0x0000 with `zero=1` and carry=1.
- WIDTH=32: SRA 0x80000000 by 4 → 0xF8000000. ROTL 0x80000001 → 0x00000003. Opcode 24 → 0 with `zero=1`.
